// File: rtl/matrix_result_unloader.sv
//============================================================================
// Module   : matrix_result_unloader
// Desc     : Snapshots a 3x3 result matrix on capture and streams it out
//            row-major, one element per valid/ready beat. Optional trailing
//            checksum beat is enabled with macro UNLOAD_CHECKSUM_EN.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module matrix_result_unloader #(
  parameter int DW = 10,
  parameter int IW = 4
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            capture,
  input  logic [9*DW-1:0] res_flat,
  output logic [DW-1:0]   out_data,
  output logic [IW-1:0]   out_index,
  output logic            out_valid,
  output logic            out_last,
  input  logic            out_ready,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

`ifdef UNLOAD_CHECKSUM_EN
  localparam logic [IW-1:0] LAST_IDX = IW'(9);
`else
  localparam logic [IW-1:0] LAST_IDX = IW'(8);
`endif

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          overrun_q, overrun_d;
  logic [DW-1:0] buf_q [9];
  logic [DW-1:0] buf_d [9];
  logic          load;
  logic          xfer;
  logic          is_last;
  logic [DW-1:0] elem;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    load      = 1'b0;
    xfer      = (state_q == STREAM) && out_ready;
    is_last   = (idx_q == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer && is_last) begin
          // A capture coinciding with the final transfer chains straight on.
          if (capture) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) idx_d = idx_q + IW'(1);
          if (capture) overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      buf_d[k] = load ? res_flat[k*DW +: DW] : buf_q[k];
    end
  end

`ifdef UNLOAD_CHECKSUM_EN
  logic [DW-1:0] chk_q, chk_d, chk_sum;

  always_comb begin
    chk_sum = '0;
    for (int k = 0; k < 9; k++) begin
      chk_sum = chk_sum + res_flat[k*DW +: DW];
    end
    chk_d = load ? chk_sum : chk_q;
  end

  always_ff @(posedge clk) begin
    if (clear) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  always_comb begin
    elem = (idx_q == IW'(9)) ? chk_q : buf_q[idx_q];
  end
`else
  always_comb begin
    elem = buf_q[idx_q];
  end
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < 9; k++) buf_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < 9; k++) buf_q[k] <= buf_d[k];
    end
  end

  always_comb begin
    out_valid = (state_q == STREAM);
    out_data  = out_valid ? elem : '0;
    out_index = out_valid ? idx_q : '0;
    out_last  = out_valid && is_last;
    busy      = (state_q == STREAM);
    overrun   = overrun_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_result_unloader.sv
//============================================================================
// Module   : tb_matrix_result_unloader
// Desc     : Scoreboard bench for matrix_result_unloader.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_matrix_result_unloader;

  localparam int DW = 10;
  localparam int IW = 4;
`ifdef UNLOAD_CHECKSUM_EN
  localparam int NBEATS = 10;
`else
  localparam int NBEATS = 9;
`endif

  logic            clk = 1'b0;
  logic            clear = 1'b1;
  logic            capture = 1'b0;
  logic [9*DW-1:0] res_flat = '0;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_index;
  logic            out_valid;
  logic            out_last;
  logic            out_ready = 1'b0;
  logic            busy;
  logic            overrun;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  logic [9*DW-1:0] m1, m2, mones;

  matrix_result_unloader #(.DW(DW), .IW(IW)) dut (
    .clk(clk), .clear(clear), .capture(capture), .res_flat(res_flat),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Beats are sampled on the falling edge; inputs are stable then.
  always @(negedge clk) begin
    if (!clear && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL extra_beat: got data=%0d index=%0d, expected no beat", out_data, out_index);
      end else begin
        beat_t e;
        e = sb.pop_front();
        if (out_data !== e.d || out_index !== e.i || out_last !== e.l) begin
          failures++;
          $display("FAIL beat: got data=%0d index=%0d last=%0b, expected data=%0d index=%0d last=%0b",
                   out_data, out_index, out_last, e.d, e.i, e.l);
        end
      end
    end
  end

  function automatic logic [9*DW-1:0] pack9(input int unsigned v [9]);
    logic [9*DW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[k*DW +: DW] = DW'(v[k]);
    return r;
  endfunction

  function automatic logic [DW-1:0] elem_of(input logic [9*DW-1:0] m, input int k);
    return m[k*DW +: DW];
  endfunction

  task automatic push_matrix(input logic [9*DW-1:0] m);
    logic [DW-1:0] sum;
    beat_t b;
    sum = '0;
    for (int k = 0; k < 9; k++) begin
      b.d = m[k*DW +: DW];
      b.i = IW'(k);
      b.l = (k == NBEATS - 1);
      sum = sum + m[k*DW +: DW];
      sb.push_back(b);
    end
    if (NBEATS == 10) begin
      b.d = sum;
      b.i = IW'(9);
      b.l = 1'b1;
      sb.push_back(b);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick;
      n++;
    end
  endtask

  task automatic start_capture(input logic [9*DW-1:0] m);
    res_flat = m;
    capture = 1'b1;
    push_matrix(m);
    tick;
    capture = 1'b0;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    tick;
    tick;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got valid=%0b last=%0b busy=%0b, expected all 0", out_valid, out_last, busy);
    end
    checks++;
    if (overrun !== 1'b0 || out_data !== '0 || out_index !== '0) begin
      failures++;
      $display("FAIL reset_data: got overrun=%0b data=%0d index=%0d, expected all 0", overrun, out_data, out_index);
    end
  endtask

  task automatic test_basic;
    int n;
    out_ready = 1'b1;
    start_capture(m1);
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== 10'd66 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: got valid=%0b index=%0d data=%0d busy=%0b, expected 1 0 66 1",
               out_valid, out_index, out_data, busy);
    end
    drain(n);
    checks++;
    if (n !== NBEATS) begin
      failures++;
      $display("FAIL basic_beat_count: got %0d cycles, expected %0d", n, NBEATS);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: got valid=%0b busy=%0b overrun=%0b, expected 0 0 0", out_valid, busy, overrun);
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic pv, pr, pl;
    logic [DW-1:0] pd;
    logic [IW-1:0] pi;
    start_capture(m1);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      out_ready = (n % 3 == 0);
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
      tick;
      n++;
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_index !== pi || out_last !== pl) begin
          failures++;
          $display("FAIL bp_hold: got valid=%0b data=%0d index=%0d last=%0b, expected 1 %0d %0d %0b",
                   out_valid, out_data, out_index, out_last, pd, pi, pl);
        end
      end
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: got %0d beats pending valid=%0b, expected 0 0", sb.size(), out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_overrun;
    int n;
    start_capture(m1);
    n = 0;
    while (out_index !== IW'(4) && n < 20) begin
      tick;
      n++;
    end
    res_flat = m2;
    capture = 1'b1;
    tick;
    capture = 1'b0;
    checks++;
    if (overrun !== 1'b1 || out_valid !== 1'b1 || out_index !== IW'(5) || out_data !== 10'd74) begin
      failures++;
      $display("FAIL overrun_set: got overrun=%0b valid=%0b index=%0d data=%0d, expected 1 1 5 74",
               overrun, out_valid, out_index, out_data);
    end
    drain(n);
    checks++;
    if (sb.size() != 0 || overrun !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL overrun_sticky: got pending=%0d overrun=%0b busy=%0b, expected 0 1 0", sb.size(), overrun, busy);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: got %0b, expected 0", overrun);
    end
    start_capture(m1);
    n = 0;
    while (!(out_valid && out_last) && n < 20) begin
      tick;
      n++;
    end
    start_capture(mones);
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== 10'd1023 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got valid=%0b index=%0d data=%0d overrun=%0b, expected 1 0 1023 0",
               out_valid, out_index, out_data, overrun);
    end
    drain(n);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: got pending=%0d busy=%0b, expected 0 0", sb.size(), busy);
    end
  endtask

  task automatic test_clear_mid;
    int n;
    start_capture(m1);
    n = 0;
    while (out_index !== IW'(3) && n < 20) begin
      tick;
      n++;
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL clear_abort: got valid=%0b busy=%0b overrun=%0b last=%0b, expected all 0",
               out_valid, busy, overrun, out_last);
    end
    sb.delete();
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_beats: got valid=%0b, expected 0", out_valid);
    end
    start_capture(m2);
    checks++;
    if (out_index !== '0 || out_data !== elem_of(m2, 0) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_restart: got index=%0d data=%0d valid=%0b, expected 0 %0d 1",
               out_index, out_data, out_valid, elem_of(m2, 0));
    end
    drain(n);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL clear_drain: got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_capture_clear_together;
    res_flat = m2;
    capture = 1'b1;
    clear = 1'b1;
    tick;
    capture = 1'b0;
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_wins: got valid=%0b busy=%0b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_snapshot;
    int n;
    start_capture(m1);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      for (int k = 0; k < 9; k++) res_flat[k*DW +: DW] = DW'($urandom_range(0, 1023));
      tick;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL snapshot_drain: got pending=%0d valid=%0b, expected 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    m1    = pack9('{66, 57, 37, 141, 117, 74, 107, 59, 26});
    m2    = pack9('{1, 2, 3, 4, 5, 6, 7, 8, 9});
    mones = pack9('{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023});
    test_reset;
    test_basic;
    test_backpressure;
    test_overrun;
    test_back_to_back;
    test_clear_mid;
    test_capture_clear_together;
    test_snapshot;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
